// File: rtl/cpu_pkg.sv
// Shared CPU encodings: program-counter operations, config-write selectors
// and quantum timer states.
package cpu_pkg;

  localparam int QUANTUM_W  = 16;
  localparam int CS_COUNT_W = 8;

  typedef enum logic [2:0] {
    PC_HOLD  = 3'd0,
    PC_INC   = 3'd1,
    PC_JUMP  = 3'd2,
    PC_DELAY = 3'd3
  } pcOp_t;

  typedef enum logic [1:0] {
    SETV_NONE      = 2'd0,
    SETV_QUANTUM   = 2'd1,
    SETV_MULTIPROG = 2'd2,
    SETV_ADDR_CS   = 2'd3
  } setVal_t;

  typedef enum logic [1:0] {
    Q_IDLE   = 2'd0,
    Q_RUN    = 2'd1,
    Q_SWITCH = 2'd2
  } qState_t;

  function automatic logic [CS_COUNT_W-1:0] satInc(input logic [CS_COUNT_W-1:0] v);
    return (v == {CS_COUNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/program_counter_unit_quantum_timer.sv
// Multiprogramming quantum timer: counts committed instructions of a user
// process and raises a one-cycle registered flagCS when its quantum expires.
module quantum_timer
  import cpu_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 freeze,
  input  logic                 commit,
  input  logic                 execProc,
  input  logic                 halt,
  input  logic                 multiprog,
  input  logic [QUANTUM_W-1:0] quantum,
  output logic                 flagCS
);

  qState_t              state, stateNext;
  logic [QUANTUM_W-1:0] qcnt, qcntNext;
  logic                 flagCSNext;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= Q_IDLE;
      qcnt   <= '0;
      flagCS <= 1'b0;
    end else begin
      state  <= stateNext;
      qcnt   <= qcntNext;
      flagCS <= flagCSNext;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    stateNext  = state;
    qcntNext   = qcnt;
    flagCSNext = 1'b0;
    if (!freeze) begin
      case (state)
        Q_IDLE: begin
          if (execProc && multiprog && (quantum != '0)) begin
            stateNext = Q_RUN;
            qcntNext  = quantum;
          end
        end
        Q_RUN: begin
          if (halt) begin
            stateNext = Q_IDLE;
          end else if (commit) begin
            qcntNext = qcnt - 1'b1;
            if (qcnt == QUANTUM_W'(1)) begin
              stateNext  = Q_SWITCH;
              flagCSNext = 1'b1;
            end
          end
        end
        Q_SWITCH: begin
          // A switch swallowed by an interruption is re-requested afterwards.
          if (flagCS) stateNext = Q_IDLE;
          else        flagCSNext = 1'b1;
        end
        default: stateNext = Q_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/program_counter_unit.sv
// Program counter with jump/delay handling, config registers and quantum
// preemption. Define PC_CS_STATS_EN to add the csCount context-switch counter.
module program_counter_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int DELAY_CYCLES = 1000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              interruption,
  input  logic [2:0]        flagPC,
  input  logic              flagJR,
  input  logic [ADDR_W-1:0] immAddr,
  input  logic [ADDR_W-1:0] regAddr,
  input  logic [1:0]        flagSetValue,
  input  logic [DATA_W-1:0] setData,
  input  logic              flagExecProc,
  input  logic              flagHALT,
  output logic [ADDR_W-1:0] pc,
  output logic              flagCS,
  output logic [ADDR_W-1:0] pcProcess
`ifdef PC_CS_STATS_EN
  ,
  output logic [CS_COUNT_W-1:0] csCount
`endif
);

  localparam int DELAY_W = $clog2(DELAY_CYCLES + 1);
  localparam logic [DELAY_W-1:0] DELAY_LOAD = DELAY_W'(DELAY_CYCLES);

  logic [ADDR_W-1:0]    pcNext, pcProcessNext, csAddr;
  logic [DELAY_W-1:0]   delayCnt, delayNext;
  logic [QUANTUM_W-1:0] quantum;
  logic                 multiprog;
  logic                 commit;
  logic                 unusedSetData;

  assign unusedSetData = ^setData;

  always_comb begin
    pcNext        = pc;
    pcProcessNext = pcProcess;
    delayNext     = '0;
    commit        = 1'b0;
    if (interruption) begin
      delayNext = delayCnt;
    end else if (flagCS) begin
      pcProcessNext = pc;
      pcNext        = csAddr;
    end else begin
      case (flagPC)
        PC_INC: begin
          pcNext = pc + 1'b1;
          commit = 1'b1;
        end
        PC_JUMP: begin
          pcNext = flagJR ? regAddr : immAddr;
          commit = 1'b1;
        end
        PC_DELAY: begin
          // Load on entry, advance on the edge that takes the counter 1->0:
          // DELAY_CYCLES+1 edges in DELAY before pc moves on.
          if (delayCnt == '0) begin
            delayNext = DELAY_LOAD;
          end else if (delayCnt == DELAY_W'(1)) begin
            pcNext = pc + 1'b1;
            commit = 1'b1;
          end else begin
            delayNext = delayCnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc        <= '0;
      pcProcess <= '0;
      delayCnt  <= '0;
      quantum   <= '0;
      multiprog <= 1'b0;
      csAddr    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples the pre-edge values of its neighbours.
      pc        <= pcNext;
      pcProcess <= pcProcessNext;
      delayCnt  <= delayNext;
      if (!interruption) begin
        case (flagSetValue)
          SETV_QUANTUM:   quantum   <= setData[QUANTUM_W-1:0];
          SETV_MULTIPROG: multiprog <= setData[0];
          SETV_ADDR_CS:   csAddr    <= setData[ADDR_W-1:0];
          default: ;
        endcase
      end
    end
  end

  quantum_timer uTimer (
    .clock     (clock),
    .reset     (reset),
    .freeze    (interruption),
    .commit    (commit),
    .execProc  (flagExecProc),
    .halt      (flagHALT),
    .multiprog (multiprog),
    .quantum   (quantum),
    .flagCS    (flagCS)
  );

`ifdef PC_CS_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                       csCount <= '0;
    else if (flagCS && !interruption) csCount <= satInc(csCount);
  end
`endif

endmodule

// File: tb/tb_program_counter_unit.sv
// Scoreboard bench for program_counter_unit: directed scenarios plus random
// stimulus, checked against a rule-level reference model.
module tb_program_counter_unit;

  localparam int ADDR_W       = 10;
  localparam int DATA_W       = 32;
  localparam int DELAY_CYCLES = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              interruption;
  logic [2:0]        flagPC;
  logic              flagJR;
  logic [ADDR_W-1:0] immAddr, regAddr;
  logic [1:0]        flagSetValue;
  logic [DATA_W-1:0] setData;
  logic              flagExecProc, flagHALT;
  logic [ADDR_W-1:0] pc, pcProcess;
  logic              flagCS;
`ifdef PC_CS_STATS_EN
  logic [7:0]        csCount;
`endif

  program_counter_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DELAY_CYCLES(DELAY_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .interruption(interruption),
    .flagPC(flagPC), .flagJR(flagJR), .immAddr(immAddr), .regAddr(regAddr),
    .flagSetValue(flagSetValue), .setData(setData),
    .flagExecProc(flagExecProc), .flagHALT(flagHALT),
    .pc(pc), .flagCS(flagCS), .pcProcess(pcProcess)
`ifdef PC_CS_STATS_EN
    , .csCount(csCount)
`endif
  );

  always #5 clock = ~clock;

  int nChecks = 0;
  int nErrors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: architectural state only, updated from the rules.
  int  mPc, mPcProc, mQuantum, mCsAddr, mDelayed, mLeft, mCsCount;
  bit  mMulti, mRunning, mOwed, mCs;
  int  cycleNo = 0;

  typedef struct {
    int pc; bit cs; int pcProc; int csCount; int cycle;
  } exp_t;
  exp_t sb[$];

  task automatic modelStep();
    int  oldQuantum, oldCsAddr;
    bit  oldMulti, commit;
    if (!reset) begin
      mPc = 0; mPcProc = 0; mQuantum = 0; mCsAddr = 0; mDelayed = 0;
      mLeft = 0; mCsCount = 0; mMulti = 0; mRunning = 0; mOwed = 0; mCs = 0;
      return;
    end
    if (interruption) begin
      mCs = 0;
      return;
    end
    oldQuantum = mQuantum; oldMulti = mMulti; oldCsAddr = mCsAddr;
    case (flagSetValue)
      2'd1: mQuantum = int'(setData[15:0]);
      2'd2: mMulti   = setData[0];
      2'd3: mCsAddr  = int'(setData[ADDR_W-1:0]);
      default: ;
    endcase
    commit = 0;
    if (mCs) begin
      mPcProc = mPc; mPc = oldCsAddr;
      mOwed = 0; mCs = 0; mRunning = 0; mDelayed = 0;
      if (mCsCount < 255) mCsCount++;
      return;
    end
    if (flagPC == 3'd1) begin
      mPc = (mPc + 1) % (1 << ADDR_W); commit = 1;
    end else if (flagPC == 3'd2) begin
      mPc = flagJR ? int'(regAddr) : int'(immAddr); commit = 1;
    end else if (flagPC == 3'd3) begin
      if (mDelayed == DELAY_CYCLES) begin
        mPc = (mPc + 1) % (1 << ADDR_W); commit = 1; mDelayed = 0;
      end else mDelayed++;
    end
    if (flagPC != 3'd3) mDelayed = 0;
    if (mOwed) mCs = 1;
    else if (mRunning) begin
      if (flagHALT) mRunning = 0;
      else if (commit) begin
        mLeft--;
        if (mLeft == 0) begin mRunning = 0; mOwed = 1; mCs = 1; end
      end
    end else if (flagExecProc && oldMulti && oldQuantum != 0) begin
      mRunning = 1; mLeft = oldQuantum;
    end
  endtask

  task automatic tick(input int n = 1);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      modelStep();
      @(posedge clock);
      e.pc = mPc; e.cs = mCs; e.pcProc = mPcProc; e.csCount = mCsCount; e.cycle = cycleNo;
      sb.push_back(e);
      cycleNo++;
      @(negedge clock);
      #1;
    end
  endtask

  // Monitor: pops one expectation per presented output sample.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("c%0d_pc", e.cycle), 32'(pc), 32'(e.pc));
        check($sformatf("c%0d_flagCS", e.cycle), 32'(flagCS), 32'(e.cs));
        check($sformatf("c%0d_pcProcess", e.cycle), 32'(pcProcess), 32'(e.pcProc));
`ifdef PC_CS_STATS_EN
        check($sformatf("c%0d_csCount", e.cycle), 32'(csCount), 32'(e.csCount));
`endif
      end
    end
  end

  task automatic idle();
    interruption = 0; flagPC = 0; flagJR = 0; immAddr = 0; regAddr = 0;
    flagSetValue = 0; setData = 0; flagExecProc = 0; flagHALT = 0;
  endtask

  task automatic setValue(input logic [1:0] sel, input int data);
    flagSetValue = sel; setData = 32'(data); tick();
    flagSetValue = 0; setData = 0;
  endtask

  task automatic execProcess(input int target);
    flagPC = 3'd2; flagJR = 1; regAddr = ADDR_W'(target); flagExecProc = 1; tick();
    flagPC = 0; flagJR = 0; flagExecProc = 0;
  endtask

  task automatic jumpImm(input int target);
    flagPC = 3'd2; flagJR = 0; immAddr = ADDR_W'(target); tick();
    flagPC = 0;
  endtask

  task automatic quantumScenario();
    setValue(2'd3, 'h200);
    setValue(2'd2, 1);
    setValue(2'd1, 3);
    execProcess('h10);
    flagPC = 3'd1; tick(3);
    check("q_cs_raised", 32'(flagCS), 1);
    flagPC = 3'd0; tick();
    check("q_pc_csaddr", 32'(pc), 'h200);
    check("q_pcProcess", 32'(pcProcess), 'h13);
    check("q_cs_dropped", 32'(flagCS), 0);
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 0;
    tick(2);
    check("reset_pc", 32'(pc), 0);
    check("reset_flagCS", 32'(flagCS), 0);
    reset = 1;

    // Increment and wrap.
    flagPC = 3'd1; tick(5);
    check("inc5_pc", 32'(pc), 5);
    jumpImm('h3FF);
    flagPC = 3'd1; tick();
    check("wrap_pc", 32'(pc), 0);

    // Jumps from both sources.
    jumpImm('h40);
    check("jump_imm", 32'(pc), 'h40);
    flagPC = 3'd2; flagJR = 1; regAddr = 'h123; tick();
    check("jump_reg", 32'(pc), 'h123);
    flagPC = 0; flagJR = 0;

    // DELAY: five edges at 7, then 8; interruption stretches the stall.
    jumpImm(7);
    flagPC = 3'd3; tick(4);
    check("delay_hold", 32'(pc), 7);
    tick();
    check("delay_done", 32'(pc), 8);
    flagPC = 0; tick();
    jumpImm(7);
    flagPC = 3'd3; tick(2);
    interruption = 1; tick(3);
    interruption = 0; tick(2);
    check("delay_int_hold", 32'(pc), 7);
    tick();
    check("delay_int_done", 32'(pc), 8);
    flagPC = 0; tick();

    // Preemption, then halt before expiry, then quantum zero.
    quantumScenario();
    execProcess('h10);
    flagPC = 3'd1; tick(2);
    flagHALT = 1; tick();
    flagHALT = 0; tick(2);
    flagPC = 0; tick(2);
    check("halt_pc", 32'(pc), 'h15);
    check("halt_no_cs", 32'(flagCS), 0);
    setValue(2'd1, 0);
    execProcess('h10);
    flagPC = 3'd1; tick(100);
    flagPC = 0; tick();
    check("q0_pc", 32'(pc), 'h74);
    setValue(2'd1, 3);
    execProcess('h10);
    flagPC = 3'd1; tick();
    flagPC = 0; reset = 0; #1;
    check("rst_run_pc", 32'(pc), 0);
    check("rst_run_pcProcess", 32'(pcProcess), 0);
    tick(2);
    reset = 1;
    execProcess('h10);
    flagPC = 3'd1; tick(4);
    flagPC = 0; tick();
    check("rst_disarmed_cs", 32'(flagCS), 0);

`ifdef PC_CS_STATS_EN
    reset = 0; tick(); reset = 1;
    quantumScenario();
    quantumScenario();
    check("cs_count_2", 32'(csCount), 2);
`endif

    // Random stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      int r;
      idle();
      r = $urandom_range(0, 9);
      if (r < 4)       flagPC = 3'd1;
      else if (r < 6)  flagPC = 3'd2;
      else if (r < 8)  flagPC = 3'd3;
      else if (r == 8) flagPC = 3'd0;
      else             flagPC = 3'($urandom_range(4, 7));
      flagJR  = 1'($urandom_range(0, 1));
      immAddr = ADDR_W'($urandom);
      regAddr = ADDR_W'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        flagSetValue = 2'($urandom_range(1, 3));
        setData = $urandom;
        setData[15:0] = 16'($urandom_range(0, 5));
        if (flagSetValue == 2'd2) setData[0] = ($urandom_range(0, 3) != 0);
      end
      flagExecProc = ($urandom_range(0, 7) == 0);
      flagHALT     = ($urandom_range(0, 31) == 0);
      interruption = ($urandom_range(0, 9) == 0);
      reset        = ($urandom_range(0, 149) != 0);
      tick();
    end
    reset = 1; idle(); tick(3);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
    if (sb.size() > 0) check("scoreboard_drain", 32'(sb.size()), 0);
    #20;
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
